// File: rtl/fb_pkg.sv
// Shared types for the 1bpp framebuffer write path: bus widths, hold entry, writer FSM states.
// Pure declarations; no latency or backpressure of its own.
package fb_pkg;

  localparam int FB_AW    = 15;
  localparam int FB_DW    = 32;
  localparam int FB_WORDS = 9600;

  typedef logic [FB_AW-1:0] fb_addr_t;
  typedef logic [FB_DW-1:0] fb_word_t;
  typedef logic [4:0]       fb_idx_t;

  typedef enum logic {RUN, FLUSH} wr_state_t;

  typedef struct packed {
    fb_addr_t addr;
    fb_word_t data;
    logic     last;
  } hold_ent_t;

  // Bits at and above idx are always zero in the pack register, so OR-ing is enough.
  function automatic fb_word_t set_pixel(fb_word_t w, fb_idx_t idx, logic d);
    return w | (fb_word_t'(d) << idx);
  endfunction

endpackage

// File: rtl/fb_word_hold.sv
// Single-entry Avalon-MM write holding register; write asserts the cycle after load.
// Backpressure: entry stays put with stable addr/data while waitrequest is high; done frees it.
module fb_word_hold
  import fb_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  hold_ent_t        load_ent,
  input  logic             waitrequest,
  output logic             full,
  output logic             write,
  output logic             done,
  output logic [FB_AW-1:0] addr,
  output logic [FB_DW-1:0] data,
  output logic             last
);

  hold_ent_t ent;

  always_ff @(posedge clk) begin
    if (reset) begin
      full <= 1'b0;
      ent  <= '0;
    end else if (load) begin
      full <= 1'b1;
      ent  <= load_ent;
    end else if (done) begin
      full <= 1'b0;
    end
  end

  // Gating with reset keeps the bus quiet during the reset cycle itself.
  assign write = full & ~reset;
  assign done  = write & ~waitrequest;
  assign addr  = reset ? '0 : ent.addr;
  assign data  = reset ? '0 : ent.data;
  assign last  = ent.last & ~reset;

endmodule

// File: rtl/fb_pixel_writer.sv
// Packs a 1bpp raster pixel stream into 32-bit Avalon-MM framebuffer writes; write rises the cycle after the 32nd pixel.
// Backpressure: pix_ready drops only at idx 31 while the hold is busy (and during FLUSH when FB_PARTIAL_FLUSH_EN is defined).
module fb_pixel_writer
  import fb_pkg::*;
#(
  parameter int unsigned WORDS_PER_FRAME = FB_WORDS,
  parameter int unsigned BASE_ADDR       = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pix_valid,
  output logic             pix_ready,
  input  logic             pix_data,
  input  logic             pix_sof,
  output logic             av_chipselect,
  output logic             av_write,
  output logic [FB_AW-1:0] av_address,
  output logic [FB_DW-1:0] av_writedata,
  input  logic             av_waitrequest,
  output logic             frame_done
);

  wr_state_t state, state_nxt;
  fb_word_t  pack, pack_nxt;
  fb_idx_t   idx, idx_nxt;
  fb_addr_t  wcnt, wcnt_nxt;
`ifdef FB_PARTIAL_FLUSH_EN
  logic      sof_bit, sof_bit_nxt;
`endif

  logic      ready;
  logic      load;
  hold_ent_t load_ent;
  logic      hold_full, hold_write, hold_done, hold_last;
  fb_addr_t  hold_addr;
  fb_word_t  hold_data;
  fb_addr_t  word_addr;
  logic      wcnt_last;

  assign word_addr = fb_addr_t'(BASE_ADDR) + wcnt;
  assign wcnt_last = (wcnt == fb_addr_t'(WORDS_PER_FRAME - 1));

  always_comb begin
    state_nxt = state;
    pack_nxt  = pack;
    idx_nxt   = idx;
    wcnt_nxt  = wcnt;
`ifdef FB_PARTIAL_FLUSH_EN
    sof_bit_nxt = sof_bit;
`endif
    ready    = 1'b0;
    load     = 1'b0;
    load_ent = '0;

    unique case (state)
      RUN: begin
        ready = !(idx == 5'd31 && hold_full && !hold_done);
        if (pix_valid && ready) begin
          if (pix_sof) begin
`ifdef FB_PARTIAL_FLUSH_EN
            if (idx != 5'd0) begin
              state_nxt   = FLUSH;
              sof_bit_nxt = pix_data;
            end else begin
              pack_nxt = fb_word_t'(pix_data);
              idx_nxt  = 5'd1;
              wcnt_nxt = '0;
            end
`else
            pack_nxt = fb_word_t'(pix_data);
            idx_nxt  = 5'd1;
            wcnt_nxt = '0;
`endif
          end else begin
            pack_nxt = set_pixel(pack, idx, pix_data);
            idx_nxt  = idx + 5'd1;
            if (idx == 5'd31) begin
              load          = 1'b1;
              load_ent.addr = word_addr;
              load_ent.data = pack_nxt;
              load_ent.last = wcnt_last;
              pack_nxt      = '0;
              wcnt_nxt      = wcnt_last ? '0 : wcnt + fb_addr_t'(1);
            end
          end
        end
      end
      FLUSH: begin
`ifdef FB_PARTIAL_FLUSH_EN
        // Partial word goes out zero-padded at the current address, then the held sof pixel starts word 0.
        if (!hold_full || hold_done) begin
          load          = 1'b1;
          load_ent.addr = word_addr;
          load_ent.data = pack;
          load_ent.last = wcnt_last;
          pack_nxt      = fb_word_t'(sof_bit);
          idx_nxt       = 5'd1;
          wcnt_nxt      = '0;
          state_nxt     = RUN;
        end
`else
        state_nxt = RUN;
`endif
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      pack  <= '0;
      idx   <= '0;
      wcnt  <= '0;
`ifdef FB_PARTIAL_FLUSH_EN
      sof_bit <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      pack  <= pack_nxt;
      idx   <= idx_nxt;
      wcnt  <= wcnt_nxt;
`ifdef FB_PARTIAL_FLUSH_EN
      sof_bit <= sof_bit_nxt;
`endif
    end
  end

  fb_word_hold u_hold (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .load_ent   (load_ent),
    .waitrequest(av_waitrequest),
    .full       (hold_full),
    .write      (hold_write),
    .done       (hold_done),
    .addr       (hold_addr),
    .data       (hold_data),
    .last       (hold_last)
  );

  assign pix_ready     = ready & ~reset;
  assign av_write      = hold_write;
  assign av_chipselect = hold_write;
  assign av_address    = hold_addr;
  assign av_writedata  = hold_data;
  assign frame_done    = hold_done & hold_last;

endmodule

// File: tb/tb_fb_pixel_writer.sv
// Bench for fb_pixel_writer: vector table, hand sequences and a randomized stream against a pixel-position model.
// Honors FB_PARTIAL_FLUSH_EN for the partial-word expectations.
module tb_fb_pixel_writer;
  import fb_pkg::*;

  localparam int WPF       = 24;
  localparam int FRAME_PIX = WPF * 32;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        pix_valid = 1'b0, pix_data = 1'b0, pix_sof = 1'b0;
  logic        av_waitrequest = 1'b0;
  logic        pix_ready, av_chipselect, av_write, frame_done;
  logic [14:0] av_address;
  logic [31:0] av_writedata;

  always #5 clk = ~clk;

  fb_pixel_writer #(.WORDS_PER_FRAME(WPF), .BASE_ADDR(0)) dut (
    .clk(clk), .reset(reset), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_data(pix_data), .pix_sof(pix_sof), .av_chipselect(av_chipselect),
    .av_write(av_write), .av_address(av_address), .av_writedata(av_writedata),
    .av_waitrequest(av_waitrequest), .frame_done(frame_done)
  );

  typedef struct packed {
    logic [14:0] addr;
    logic [31:0] data;
    logic        last;
  } wr_t;

  typedef struct {
    logic [31:0] pat;
    bit          sof;
    int          stall;
    logic [14:0] exp_addr;
    logic [31:0] exp_data;
  } vec_t;

  int  checks = 0, fails = 0;
  wr_t exp_q[$];
  wr_t log_q[$];
  int  pos = 0;
  logic [31:0] mbuf = '0;
  int  fd_cnt = 0, nr_cnt = 0, stall_left = 0;
  bit  rand_wait = 0, chk_ready = 0, prev_stall = 0;
  logic [14:0] prev_addr;
  logic [31:0] prev_data;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: every accepted pixel has a position in the frame; word = pos/32, bit = pos%32.
  task automatic model_pixel(input logic d, input logic s);
    wr_t e;
    if (s) begin
`ifdef FB_PARTIAL_FLUSH_EN
      if (pos % 32 != 0) begin
        e.addr = 15'(pos / 32); e.data = mbuf; e.last = (pos / 32 == WPF - 1);
        exp_q.push_back(e);
      end
`endif
      pos = 0; mbuf = '0;
    end
    mbuf[pos % 32] = d;
    if (pos % 32 == 31) begin
      e.addr = 15'(pos / 32); e.data = mbuf; e.last = (pos / 32 == WPF - 1);
      exp_q.push_back(e);
      mbuf = '0;
    end
    pos = (pos + 1) % FRAME_PIX;
  endtask

  initial forever begin
    @(negedge clk);
    if (reset) begin
      exp_q.delete(); pos = 0; mbuf = '0; prev_stall = 0;
    end else begin
      wr_t e, got;
      if (chk_ready && pix_valid) begin
        chk("ready_rule", pix_ready, !((pos % 32 == 31) && av_write && av_waitrequest));
        if (!pix_ready) nr_cnt++;
      end
      if (prev_stall) begin
        chk("stall_write_held", av_write, 1'b1);
        chk("stall_addr_stable", av_address, prev_addr);
        chk("stall_data_stable", av_writedata, prev_data);
      end
      chk("chipselect_eq_write", av_chipselect, av_write);
      if (av_write && !av_waitrequest) begin
        got.addr = av_address; got.data = av_writedata; got.last = frame_done;
        log_q.push_back(got);
        if (frame_done) fd_cnt++;
        chk("write_expected", 64'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("model_addr", av_address, e.addr);
          chk("model_data", av_writedata, e.data);
          chk("model_frame_done", frame_done, e.last);
        end
      end else begin
        chk("frame_done_idle", frame_done, 1'b0);
      end
      prev_stall = av_write && av_waitrequest;
      prev_addr  = av_address;
      prev_data  = av_writedata;
      if (pix_valid && pix_ready) model_pixel(pix_data, pix_sof);
    end
  end

  // Slave model: random stalls, or a programmed stall count on the next write.
  initial forever begin
    @(posedge clk); #1;
    if (rand_wait) av_waitrequest = ($urandom_range(0, 2) == 0);
    else if (av_write && stall_left > 0) begin
      av_waitrequest = 1'b1;
      stall_left--;
    end else av_waitrequest = 1'b0;
  end

  task automatic cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_pix(input logic d, input logic s);
    bit ok = 0;
    pix_valid = 1'b1; pix_data = d; pix_sof = s;
    for (int t = 0; t < 300 && !ok; t++) begin
      @(negedge clk);
      if (pix_ready) ok = 1;
      @(posedge clk); #1;
    end
    pix_valid = 1'b0; pix_sof = 1'b0;
    chk("pix_accepted", 64'(ok), 1);
  endtask

  task automatic wait_log(input int n);
    for (int t = 0; t < 2000 && log_q.size() < n; t++) cycles(1);
    chk("write_count", 64'(log_q.size()), 64'(n));
  endtask

  task automatic drain();
    for (int t = 0; t < 2000 && (exp_q.size() != 0 || av_write); t++) cycles(1);
    chk("drain_empty", 64'(exp_q.size()), 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_av_write"}, av_write, 1'b0);
    chk({tag, "_av_chipselect"}, av_chipselect, 1'b0);
    chk({tag, "_av_address"}, av_address, 15'h0);
    chk({tag, "_av_writedata"}, av_writedata, 32'h0);
    chk({tag, "_frame_done"}, frame_done, 1'b0);
    chk({tag, "_pix_ready"}, pix_ready, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[6];
    int   base;
    tbl[0] = '{32'hAAAAAAAA, 1, 0, 15'h0000, 32'hAAAAAAAA};
    tbl[1] = '{32'h12345678, 0, 3, 15'h0001, 32'h12345678};
    tbl[2] = '{32'hFFFFFFFF, 0, 0, 15'h0002, 32'hFFFFFFFF};
    tbl[3] = '{32'h00000001, 1, 0, 15'h0000, 32'h00000001};
    tbl[4] = '{32'h80000000, 0, 5, 15'h0001, 32'h80000000};
    tbl[5] = '{32'h0F0F00FF, 0, 1, 15'h0002, 32'h0F0F00FF};

    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk); #1;
    reset = 1'b0;
    cycles(1);

    // Single words, hold idle before each; write must rise right after the 32nd accept.
    for (int i = 0; i < 6; i++) begin
      base = log_q.size();
      stall_left = tbl[i].stall;
      for (int b = 0; b < 32; b++) begin
        if (b == 31) chk("tbl_idle_before_last", av_write, 1'b0);
        send_pix(tbl[i].pat[b], tbl[i].sof && b == 0);
      end
      chk("tbl_write_next_cycle", av_write, 1'b1);
      wait_log(base + 1);
      chk("tbl_addr", log_q[log_q.size()-1].addr, tbl[i].exp_addr);
      chk("tbl_data", log_q[log_q.size()-1].data, tbl[i].exp_data);
      drain();
    end

    // Partial word followed by sof.
    base = log_q.size();
    for (int i = 0; i < 10; i++) send_pix(1'b1, i == 0);
    send_pix(1'b0, 1'b1);
    for (int i = 0; i < 31; i++) send_pix(1'b0, 1'b0);
`ifdef FB_PARTIAL_FLUSH_EN
    wait_log(base + 2);
    chk("sof_flush_addr", log_q[base].addr, 15'h0);
    chk("sof_flush_data", log_q[base].data, 32'h000003FF);
    chk("sof_word0_addr", log_q[base+1].addr, 15'h0);
    chk("sof_word0_data", log_q[base+1].data, 32'h0);
    cycles(20);
    chk("sof_no_extra", 64'(log_q.size()), 64'(base + 2));
`else
    wait_log(base + 1);
    chk("sof_word0_addr", log_q[base].addr, 15'h0);
    chk("sof_word0_data", log_q[base].data, 32'h0);
    cycles(20);
    chk("sof_no_extra", 64'(log_q.size()), 64'(base + 1));
`endif
    drain();

    // Continuous stream: short stall on word 1, long stall on word 3.
    chk_ready = 1; nr_cnt = 0;
    for (int i = 0; i < 160; i++) begin
      if (i == 40) stall_left = 5;
      if (i == 100) stall_left = 40;
      send_pix(1'($urandom_range(0, 1)), i == 0);
    end
    drain();
    chk_ready = 0;
    chk("stream_ready_low_cycles", 64'(nr_cnt), 9);

    // Two full frames plus three words, random gaps and stalls.
    rand_wait = 1;
    base = fd_cnt;
    for (int w = 0; w < 2 * WPF + 3; w++)
      for (int b = 0; b < 32; b++) begin
        if ($urandom_range(0, 7) == 0) begin pix_valid = 1'b0; cycles($urandom_range(1, 3)); end
        send_pix(1'($urandom_range(0, 1)), w == 0 && b == 0);
      end
    drain();
    chk("frame_done_pulses", 64'(fd_cnt - base), 2);

    // Random stream with occasional sof.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 9) == 0) begin pix_valid = 1'b0; cycles(1); end
      send_pix(1'($urandom_range(0, 1)), $urandom_range(0, 59) == 0);
    end
    drain();
    rand_wait = 0;
    cycles(2);

    // Reset while a write is stalled.
    stall_left = 1000;
    for (int b = 0; b < 32; b++) send_pix(b[0], b == 0);
    for (int t = 0; t < 50 && !av_write; t++) cycles(1);
    chk("rst_write_pending", av_write, 1'b1);
    cycles(2);
    chk("rst_stalled", av_waitrequest, 1'b1);
    base = log_q.size();
    reset = 1'b1;
    @(negedge clk);
    chk_all_zero("midreset");
    @(posedge clk); #1;
    @(negedge clk);
    chk_all_zero("midreset_next");
    @(posedge clk); #1;
    reset = 1'b0;
    stall_left = 0;
    for (int b = 0; b < 32; b++) send_pix(b < 16, 1'b0);
    wait_log(base + 1);
    chk("post_reset_addr", log_q[base].addr, 15'h0);
    chk("post_reset_data", log_q[base].data, 32'h0000FFFF);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
